// File: rtl/masked_hpc2_sched.sv
// masked_hpc2_sched: round-robin issue controller and arbiter for one shared HPC2 masked multiplier.
// Latency: a result is visible 3 cycles after issue; sustains one issue per cycle.
// Backpressure: a credit guard (FIFO occupancy + in-flight) blocks issue, so the multiplier never stalls.
// Optional feature macro: HPC2_SCHED_IDLE_ZERO_EN zeroes multiplier inputs in non-issue cycles.

// masked_hpc2_mul: HPC2 masked GF(2^n) multiplier, b/r sampled one cycle before a.
// Latency: 2 cycles from b/r (cycle T) to o_c (cycle T+2); a is presented in T+1.
// Backpressure: none, fully pipelined, accepts one operation every cycle.
module masked_hpc2_mul #(
   parameter int NUM_SHARES = 2,
   parameter int BIT_WIDTH  = 2
) (
   input  logic                                            i_clk,
   input  logic                                            i_rst,
   input  logic [NUM_SHARES*BIT_WIDTH-1:0]                 i_a,
   input  logic [NUM_SHARES*BIT_WIDTH-1:0]                 i_b,
   input  logic [NUM_SHARES*(NUM_SHARES-1)/2*BIT_WIDTH-1:0] i_r,
   output logic [NUM_SHARES*BIT_WIDTH-1:0]                 o_c
);
   localparam int BW     = BIT_WIDTH;
   localparam int NS     = NUM_SHARES;
   // Low bits of the reduction polynomial (x^2+x+1, x^3+x+1, x^4+x+1, AES x^8+x^4+x^3+x+1).
   localparam int POLY_I = (BW == 8) ? 'h1B : ((BW <= 4) ? 3 : 1);
   localparam logic [BW-1:0] POLY = POLY_I[BW-1:0];

   logic [NS-1:0][NS-1:0][BW-1:0] w_rmat;
   logic [NS-1:0][NS-1:0][BW-1:0] r_s1;
   logic [NS-1:0][NS-1:0][BW-1:0] r_rr;
   logic [NS-1:0][NS-1:0][BW-1:0] r_m0;
   logic [NS-1:0][NS-1:0][BW-1:0] r_m1;
   logic [NS-1:0][NS-1:0][BW-1:0] r_m2;

   function automatic int quad_idx(input int i, input int j);
      return i*NS - (i*(i+1))/2 + (j-i-1);
   endfunction

   function automatic logic [BW-1:0] gf_mul(input logic [BW-1:0] x, input logic [BW-1:0] y);
      logic [BW-1:0] acc;
      logic [BW-1:0] t;
      acc = '0;
      t   = x;
      for (int k = 0; k < BW; k++) begin
         if (y[k]) acc = acc ^ t;
         t = t[BW-1] ? ((t << 1) ^ POLY) : (t << 1);
      end
      return acc;
   endfunction

   // Symmetric randomness matrix: r_ij = r_ji, zero on the diagonal.
   always_comb begin
      w_rmat = '0;
      for (int i = 0; i < NS; i++)
         for (int j = i+1; j < NS; j++) begin
            w_rmat[i][j] = i_r[quad_idx(i, j)*BW +: BW];
            w_rmat[j][i] = i_r[quad_idx(i, j)*BW +: BW];
         end
   end

   // Stage 1: register b_i, (b_j ^ r_ij) and r_ij before they meet a.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1 <= '0;
         r_rr <= '0;
      end else begin
         for (int i = 0; i < NS; i++)
            for (int j = 0; j < NS; j++)
               r_s1[i][j] <= (i == j) ? i_b[i*BW +: BW] : (i_b[j*BW +: BW] ^ w_rmat[i][j]);
         r_rr <= w_rmat;
      end
   end

   // Stage 2: each partial product gets its own register so no glitchy XOR precedes a register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_m0 <= '0;
         r_m1 <= '0;
         r_m2 <= '0;
      end else begin
         for (int i = 0; i < NS; i++)
            for (int j = 0; j < NS; j++) begin
               r_m0[i][j] <= gf_mul(i_a[i*BW +: BW], r_s1[i][j]);
               r_m1[i][j] <= gf_mul(i_a[i*BW +: BW], r_rr[i][j]);
               r_m2[i][j] <= r_rr[i][j];
            end
      end
   end

   // Share compression: c_i = a_i*b_i ^ sum_j (a_i*b_j ^ r_ij); the r_ij cancel across shares.
   always_comb begin
      o_c = '0;
      for (int i = 0; i < NS; i++)
         for (int j = 0; j < NS; j++)
            o_c[i*BW +: BW] = o_c[i*BW +: BW] ^ r_m0[i][j] ^ r_m1[i][j] ^ r_m2[i][j];
   end
endmodule

// hpc2_sched_fifo: circular result buffer, head/tail wrap modulo DEPTH.
// Latency: pushed entry visible at the output the cycle after the push.
// Backpressure: none internally; the caller's credit guard prevents pushes into a full buffer.
module hpc2_sched_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_dat,
   input  logic             i_pop,
   output logic             o_vld,
   output logic [WIDTH-1:0] o_dat
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic             w_pop;
   logic             w_push;

   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);
   assign o_vld  = (r_count != '0);
   assign o_dat  = o_vld ? r_mem[r_head] : '0;

   // Storage: payload needs no reset, the output is masked while empty.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_tail] <= i_dat;
   end

   // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= (r_tail == PW'(DEPTH-1)) ? '0 : r_tail + 1'b1;
         if (w_pop)  r_head <= (r_head == PW'(DEPTH-1)) ? '0 : r_head + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end
endmodule

// masked_hpc2_sched top: arbitration, randomness pairing, operand skew, ID tracking, result buffer.
// Latency: request accepted in cycle T gives out_res_valid in T+3 at the earliest.
// Backpressure: issue stalls when credits reach OUT_DEPTH; results are never dropped.
module masked_hpc2_sched #(
   parameter int NUM_SHARES = 2,
   parameter int BIT_WIDTH  = 2,
   parameter int NUM_REQ    = 2,
   parameter int OUT_DEPTH  = 4,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int SW        = NUM_SHARES*BIT_WIDTH,
   localparam int RW        = NUM_SHARES*(NUM_SHARES-1)/2*BIT_WIDTH
) (
   input  logic                  in_clock,
   input  logic                  in_reset,
   input  logic [NUM_REQ-1:0]    in_req_valid,
   output logic [NUM_REQ-1:0]    out_req_ready,
   input  logic [NUM_REQ*SW-1:0] in_req_a,
   input  logic [NUM_REQ*SW-1:0] in_req_b,
   input  logic                  in_rand_valid,
   output logic                  out_rand_ready,
   input  logic [RW-1:0]         in_rand,
   output logic                  out_res_valid,
   input  logic                  in_res_ready,
   output logic [SW-1:0]         out_res_c,
   output logic [ID_W-1:0]       out_res_id
);
   localparam int CW = $clog2(OUT_DEPTH+1);

   logic [ID_W-1:0] r_last_grant;
   logic [CW-1:0]   r_credits;
   logic [SW-1:0]   r_a_t1;
   logic            r_v1, r_v2;
   logic [ID_W-1:0] r_id1, r_id2;

   logic [ID_W-1:0] w_cand;
   logic            w_any;
   logic            w_issue;
   logic            w_pop;
   logic [SW-1:0]   w_cand_a, w_cand_b, w_a_nxt;
   logic [SW-1:0]   w_mul_a, w_mul_b, w_mul_c;
   logic [RW-1:0]   w_mul_r;

   // Round-robin candidate: first valid requester scanning from last_grant+1.
   always_comb begin
      int start;
      int idx;
      start  = (int'(r_last_grant) + 1) % NUM_REQ;
      w_cand = ID_W'(start);
      w_any  = 1'b0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         idx = (start + k) % NUM_REQ;
         if (in_req_valid[idx]) begin
            w_cand = ID_W'(idx);
            w_any  = 1'b1;
         end
      end
   end

   assign w_issue        = !in_reset && w_any && in_rand_valid && (r_credits < CW'(OUT_DEPTH));
   assign out_req_ready  = w_issue ? (NUM_REQ'(1) << w_cand) : '0;
   assign out_rand_ready = w_issue;
   assign w_cand_a       = in_req_a[w_cand*SW +: SW];
   assign w_cand_b       = in_req_b[w_cand*SW +: SW];
   assign w_pop          = out_res_valid && in_res_ready;
   assign w_mul_a        = r_a_t1;

`ifdef HPC2_SCHED_IDLE_ZERO_EN
   assign w_mul_b = w_issue ? w_cand_b : '0;
   assign w_mul_r = w_issue ? in_rand  : '0;
   assign w_a_nxt = w_issue ? w_cand_a : '0;
`else
   assign w_mul_b = w_cand_b;
   assign w_mul_r = in_rand;
   assign w_a_nxt = w_cand_a;
`endif

   // Operand skew and 2-stage valid/ID tracking aligned with the multiplier pipeline.
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         r_a_t1 <= '0;
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_id1  <= '0;
         r_id2  <= '0;
      end else begin
         r_a_t1 <= w_a_nxt;
         r_v1   <= w_issue;
         r_id1  <= w_cand;
         r_v2   <= r_v1;
         r_id2  <= r_id1;
      end
   end

   // Arbiter pointer and credit counter (occupancy + in-flight).
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         r_last_grant <= ID_W'(NUM_REQ-1);
         r_credits    <= '0;
      end else begin
         if (w_issue) r_last_grant <= w_cand;
         if (w_issue && !w_pop)      r_credits <= r_credits + 1'b1;
         else if (!w_issue && w_pop) r_credits <= r_credits - 1'b1;
      end
   end

   masked_hpc2_mul #(
      .NUM_SHARES (NUM_SHARES),
      .BIT_WIDTH  (BIT_WIDTH)
   ) u_mul (
      .i_clk (in_clock),
      .i_rst (in_reset),
      .i_a   (w_mul_a),
      .i_b   (w_mul_b),
      .i_r   (w_mul_r),
      .o_c   (w_mul_c)
   );

   hpc2_sched_fifo #(
      .WIDTH (SW + ID_W),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .i_clk  (in_clock),
      .i_rst  (in_reset),
      .i_push (r_v2),
      .i_dat  ({w_mul_c, r_id2}),
      .i_pop  (w_pop),
      .o_vld  (out_res_valid),
      .o_dat  ({out_res_c, out_res_id})
   );
endmodule

// File: tb/tb_masked_hpc2_sched.sv
// Directed bench for masked_hpc2_sched with NUM_SHARES=2, BIT_WIDTH=2, NUM_REQ=2, OUT_DEPTH=4.
module tb_masked_hpc2_sched;
   logic       in_clock = 1'b0;
   logic       in_reset;
   logic [1:0] in_req_valid;
   logic [1:0] out_req_ready;
   logic [7:0] in_req_a;
   logic [7:0] in_req_b;
   logic       in_rand_valid;
   logic       out_rand_ready;
   logic [1:0] in_rand;
   logic       out_res_valid;
   logic       in_res_ready;
   logic [3:0] out_res_c;
   logic [0:0] out_res_id;

   int n_checks = 0;
   int n_errors = 0;

   // Requester operands: req0 a=3, b=2 ; req1 a=2, b=2 (share XORs), GF(4) with x^2=x+1.
   localparam logic [3:0] A0 = 4'b0110;
   localparam logic [3:0] B0 = 4'b1101;
   localparam logic [3:0] A1 = 4'b1101;
   localparam logic [3:0] B1 = 4'b0111;

   function automatic logic [1:0] gf4(input logic [1:0] x, input logic [1:0] y);
      return {(x[1]&y[1]) ^ (x[1]&y[0]) ^ (x[0]&y[1]), (x[1]&y[1]) ^ (x[0]&y[0])};
   endfunction

   function automatic logic [1:0] exp_c(input logic id);
      if (id) return gf4(A1[1:0]^A1[3:2], B1[1:0]^B1[3:2]);
      return gf4(A0[1:0]^A0[3:2], B0[1:0]^B0[3:2]);
   endfunction

   always #5 in_clock = ~in_clock;

   masked_hpc2_sched dut (
      .in_clock       (in_clock),
      .in_reset       (in_reset),
      .in_req_valid   (in_req_valid),
      .out_req_ready  (out_req_ready),
      .in_req_a       (in_req_a),
      .in_req_b       (in_req_b),
      .in_rand_valid  (in_rand_valid),
      .out_rand_ready (out_rand_ready),
      .in_rand        (in_rand),
      .out_res_valid  (out_res_valid),
      .in_res_ready   (in_res_ready),
      .out_res_c      (out_res_c),
      .out_res_id     (out_res_id)
   );

   task automatic test_reset();
      in_reset = 1'b1; in_req_valid = 2'b11; in_rand_valid = 1'b1; in_res_ready = 1'b1;
      repeat (2) @(negedge in_clock);
      #1;
      n_checks++; if (out_res_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_res_valid); end
      n_checks++; if (out_res_c !== 4'h0) begin n_errors++; $display("FAIL reset_c: got %h want 0", out_res_c); end
      n_checks++; if (out_res_id !== 1'b0) begin n_errors++; $display("FAIL reset_id: got %b want 0", out_res_id); end
      n_checks++; if (out_req_ready !== 2'b00) begin n_errors++; $display("FAIL reset_req_ready: got %b want 00", out_req_ready); end
      n_checks++; if (out_rand_ready !== 1'b0) begin n_errors++; $display("FAIL reset_rand_ready: got %b want 0", out_rand_ready); end
      @(negedge in_clock);
      in_req_valid = 2'b00; in_reset = 1'b0;
   endtask

   task automatic test_single();
      repeat (3) @(negedge in_clock);
      in_req_valid = 2'b01; in_rand = 2'b10;
      #1;
      n_checks++; if (out_req_ready !== 2'b01) begin n_errors++; $display("FAIL single_grant: got %b want 01", out_req_ready); end
      n_checks++; if (out_rand_ready !== 1'b1) begin n_errors++; $display("FAIL single_rand_ready: got %b want 1", out_rand_ready); end
      for (int k = 1; k <= 3; k++) begin
         @(negedge in_clock);
         in_req_valid = 2'b00;
         #1;
         if (k < 3) begin
            n_checks++; if (out_res_valid !== 1'b0) begin n_errors++; $display("FAIL single_early_valid: cycle +%0d got %b want 0", k, out_res_valid); end
         end else begin
            n_checks++; if (out_res_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b want 1", out_res_valid); end
            n_checks++; if (out_res_id !== 1'b0) begin n_errors++; $display("FAIL single_id: got %b want 0", out_res_id); end
            n_checks++; if ((out_res_c[1:0] ^ out_res_c[3:2]) !== 2'b01) begin n_errors++; $display("FAIL single_product: got %b want 01", out_res_c[1:0] ^ out_res_c[3:2]); end
         end
      end
      @(negedge in_clock);
      #1;
      n_checks++; if (out_res_valid !== 1'b0) begin n_errors++; $display("FAIL single_popped: got %b want 0", out_res_valid); end
   endtask

   task automatic test_round_robin();
      logic       q_id [$];
      logic [1:0] q_c  [$];
      int         first = -1;
      @(negedge in_clock); in_reset = 1'b1;
      @(negedge in_clock); in_reset = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge in_clock);
         in_req_valid = (cyc < 6) ? 2'b11 : 2'b00;
         in_rand = 2'(cyc*3 + 1);
         #1;
         if (cyc < 6) begin
            n_checks++; if (out_req_ready !== ((cyc % 2 == 0) ? 2'b01 : 2'b10)) begin n_errors++; $display("FAIL rr_grant: cycle %0d got %b", cyc, out_req_ready); end
         end
         if (out_res_valid === 1'b1) begin
            if (first < 0) first = cyc;
            q_id.push_back(out_res_id[0]);
            q_c.push_back(out_res_c[1:0] ^ out_res_c[3:2]);
         end
      end
      n_checks++; if (first != 3) begin n_errors++; $display("FAIL rr_latency: first result cycle %0d want 3", first); end
      n_checks++; if (q_id.size() != 6) begin n_errors++; $display("FAIL rr_count: got %0d want 6", q_id.size()); end
      for (int i = 0; i < q_id.size(); i++) begin
         n_checks++; if (q_id[i] !== 1'(i % 2)) begin n_errors++; $display("FAIL rr_id: result %0d got %b", i, q_id[i]); end
         n_checks++; if (q_c[i] !== exp_c(1'(i % 2))) begin n_errors++; $display("FAIL rr_product: result %0d got %b want %b", i, q_c[i], exp_c(1'(i % 2))); end
      end
   endtask

   task automatic test_back_pressure();
      int issues = 0;
      in_res_ready = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge in_clock);
         in_req_valid = 2'b11;
         #1;
         if (out_req_ready !== 2'b00) issues++;
         if (cyc >= 4) begin
            n_checks++; if (out_req_ready !== 2'b00 || out_rand_ready !== 1'b0) begin n_errors++; $display("FAIL bp_stall: cycle %0d ready %b rand %b", cyc, out_req_ready, out_rand_ready); end
         end
      end
      n_checks++; if (issues != 4) begin n_errors++; $display("FAIL bp_issues: got %0d want 4", issues); end
      n_checks++; if (out_res_valid !== 1'b1 || out_res_id !== 1'b0) begin n_errors++; $display("FAIL bp_head: valid %b id %b want 1/0", out_res_valid, out_res_id); end
      for (int k = 0; k < 4; k++) begin
         @(negedge in_clock);
         in_res_ready = 1'b1;
         #1;
         n_checks++; if (out_res_valid !== 1'b1 || out_res_id !== 1'(k % 2)) begin n_errors++; $display("FAIL bp_release: k %0d valid %b id %b", k, out_res_valid, out_res_id); end
         n_checks++; if ((out_res_c[1:0] ^ out_res_c[3:2]) !== exp_c(1'(k % 2))) begin n_errors++; $display("FAIL bp_product: k %0d got %b", k, out_res_c[1:0] ^ out_res_c[3:2]); end
         if (k == 0) begin
            n_checks++; if (out_req_ready !== 2'b00) begin n_errors++; $display("FAIL bp_full_hold: got %b want 00", out_req_ready); end
         end
         if (k == 1) begin
            n_checks++; if (out_req_ready !== 2'b01) begin n_errors++; $display("FAIL bp_resume: got %b want 01", out_req_ready); end
         end
      end
      @(negedge in_clock);
      in_req_valid = 2'b00;
      repeat (8) @(negedge in_clock);
   endtask

   task automatic test_rand_starve();
      for (int k = 0; k < 3; k++) begin
         @(negedge in_clock);
         in_req_valid = 2'b01; in_rand_valid = 1'b0;
         #1;
         n_checks++; if (out_req_ready !== 2'b00 || out_rand_ready !== 1'b0) begin n_errors++; $display("FAIL starve: k %0d ready %b rand %b", k, out_req_ready, out_rand_ready); end
      end
      @(negedge in_clock);
      in_rand_valid = 1'b1;
      #1;
      n_checks++; if (out_req_ready !== 2'b01 || out_rand_ready !== 1'b1) begin n_errors++; $display("FAIL starve_resume: ready %b rand %b", out_req_ready, out_rand_ready); end
      @(negedge in_clock);
      in_req_valid = 2'b00;
      repeat (5) @(negedge in_clock);
   endtask

   task automatic test_reset_midflight();
      int stale = 0;
      @(negedge in_clock);
      in_req_valid = 2'b11;
      #1;
      n_checks++; if (out_req_ready !== 2'b10) begin n_errors++; $display("FAIL mid_grant1: got %b want 10", out_req_ready); end
      @(negedge in_clock);
      #1;
      n_checks++; if (out_req_ready !== 2'b01) begin n_errors++; $display("FAIL mid_grant2: got %b want 01", out_req_ready); end
      @(negedge in_clock);
      in_req_valid = 2'b00; in_reset = 1'b1;
      #1;
      n_checks++; if (out_res_valid !== 1'b0) begin n_errors++; $display("FAIL mid_valid: got %b want 0", out_res_valid); end
      @(negedge in_clock);
      @(negedge in_clock);
      in_reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge in_clock);
         #1;
         if (out_res_valid !== 1'b0) stale++;
      end
      n_checks++; if (stale != 0) begin n_errors++; $display("FAIL mid_stale: %0d cycles with valid, want 0", stale); end
      @(negedge in_clock);
      in_req_valid = 2'b11;
      #1;
      n_checks++; if (out_req_ready !== 2'b01) begin n_errors++; $display("FAIL mid_first_grant: got %b want 01", out_req_ready); end
      @(negedge in_clock);
      in_req_valid = 2'b00;
      repeat (5) @(negedge in_clock);
      // Buffered result held by a stalled downstream, then an asynchronous reset between edges.
      in_res_ready = 1'b0; in_req_valid = 2'b01;
      repeat (3) begin
         @(negedge in_clock);
         in_req_valid = 2'b00;
      end
      #1;
      n_checks++; if (out_res_valid !== 1'b1) begin n_errors++; $display("FAIL mid_buffered: got %b want 1", out_res_valid); end
      #2;
      in_reset = 1'b1;
      #1;
      n_checks++; if (out_res_valid !== 1'b0 || out_res_c !== 4'h0) begin n_errors++; $display("FAIL mid_async: valid %b c %h want 0/0", out_res_valid, out_res_c); end
      @(negedge in_clock);
      @(negedge in_clock);
      in_reset = 1'b0; in_res_ready = 1'b1;
   endtask

   task automatic test_idle();
      @(negedge in_clock);
      in_req_valid = 2'b10; in_rand = 2'b11;
      #1;
      n_checks++; if (out_req_ready !== 2'b10) begin n_errors++; $display("FAIL idle_grant: got %b want 10", out_req_ready); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge in_clock);
         in_req_valid = 2'b00;
         #1;
`ifdef HPC2_SCHED_IDLE_ZERO_EN
         n_checks++; if (dut.w_mul_b !== 4'h0 || dut.w_mul_r !== 2'b00) begin n_errors++; $display("FAIL idle_br: k %0d b %h r %b want 0", k, dut.w_mul_b, dut.w_mul_r); end
         if (k >= 2) begin
            n_checks++; if (dut.w_mul_a !== 4'h0) begin n_errors++; $display("FAIL idle_a: k %0d got %h want 0", k, dut.w_mul_a); end
         end
`endif
         if (k == 3) begin
            n_checks++; if (out_res_valid !== 1'b1 || out_res_id !== 1'b1) begin n_errors++; $display("FAIL idle_result: valid %b id %b want 1/1", out_res_valid, out_res_id); end
            n_checks++; if ((out_res_c[1:0] ^ out_res_c[3:2]) !== exp_c(1'b1)) begin n_errors++; $display("FAIL idle_product: got %b want %b", out_res_c[1:0] ^ out_res_c[3:2], exp_c(1'b1)); end
         end
      end
   endtask

   initial begin
      in_reset = 1'b1; in_req_valid = 2'b00; in_rand_valid = 1'b1; in_rand = 2'b00;
      in_res_ready = 1'b1; in_req_a = {A1, A0}; in_req_b = {B1, B0};
      test_reset();
      test_single();
      test_round_robin();
      test_back_pressure();
      test_rand_starve();
      test_reset_midflight();
      test_idle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
